// File: rtl/proj_param_pkg.sv
// Project-wide sizing shared by the pad-ring blocks.
package proj_param_pkg;
    localparam int PROJ_GPIO = 32;
endpackage

// File: rtl/verilab_pads_pkg.sv
// Default widths for the pad-side GPIO input conditioning blocks.
package verilab_pads_pkg;
    localparam int DEFAULT_PRESC_W  = 16;
    localparam int DEFAULT_DB_CNT_W = 8;
endpackage

// File: rtl/verilab_pads_gpio_db_cell.sv
// One GPIO pin: 2-flop synchroniser, tick-based debounce, stable value,
// edge detect and sticky W1C interrupt status bit.
module verilab_pads_gpio_db_cell
    import verilab_pads_pkg::*;
#(
    parameter int DB_CNT_W = DEFAULT_DB_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pad,
    input  logic                tick,
    input  logic [DB_CNT_W-1:0] db_limit,
    input  logic                db_en,
    input  logic                rise_en,
    input  logic                fall_en,
    input  logic                int_clr,
    output logic                stable,
    output logic                status
);

    logic                sync_q1;
    logic                sync_q2;
    logic                stable_q;
    logic                prev_q;
    logic                status_q;
    logic                db_en_q;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_inc;
    logic                rise;
    logic                fall;
    logic                set;
    logic                accept;

    // Saturating increment so a long run at the max limit never wraps back to 0.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + DB_CNT_W'(1);

    assign accept = (db_limit == '0) || (tick && (cnt_inc >= db_limit));

    assign rise = stable_q & ~prev_q;
    assign fall = ~stable_q & prev_q;
    assign set  = (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            status_q <= 1'b0;
            db_en_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q1  <= pad;
            sync_q2  <= sync_q1;
            db_en_q  <= db_en;
            prev_q   <= stable_q;
            status_q <= set | (status_q & ~int_clr);

            // A mode change restarts the count; the new mode applies from the next cycle.
            if (db_en != db_en_q) begin
                cnt_q <= '0;
            end else if (!db_en) begin
                stable_q <= sync_q2;
                cnt_q    <= '0;
            end else if (sync_q2 == stable_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable_q <= sync_q2;
                cnt_q    <= '0;
            end else if (tick) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign stable = stable_q;
    assign status = status_q;

endmodule

// File: rtl/verilab_pads_gpio_in_cond.sv
// GPIO input conditioner: shared debounce prescaler, per-pin conditioning
// cells and the registered masked interrupt line.
module verilab_pads_gpio_in_cond
    import verilab_pads_pkg::*;
#(
    parameter int GPIO     = proj_param_pkg::PROJ_GPIO,
    parameter int PRESC_W  = DEFAULT_PRESC_W,
    parameter int DB_CNT_W = DEFAULT_DB_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [GPIO-1:0]     pad_in,
    input  logic [PRESC_W-1:0]  presc,
    input  logic [DB_CNT_W-1:0] db_limit,
    input  logic [GPIO-1:0]     db_en,
    input  logic [GPIO-1:0]     rise_en,
    input  logic [GPIO-1:0]     fall_en,
    input  logic [GPIO-1:0]     int_mask,
    input  logic [GPIO-1:0]     int_clr,
    output logic [GPIO-1:0]     gpio_in,
    output logic [GPIO-1:0]     int_status,
    output logic                irq
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic               tick;
    logic [GPIO-1:0]    status;
    logic               irq_q;

    assign tick = (presc_cnt_q == presc);

    // Using >= lets a lowered presc pull an overshooting counter back to 0 at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
        end else if (presc_cnt_q >= presc) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
        end
    end

    for (genvar i = 0; i < GPIO; i++) begin : g_pin
        verilab_pads_gpio_db_cell #(
            .DB_CNT_W (DB_CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .pad      (pad_in[i]),
            .tick     (tick),
            .db_limit (db_limit),
            .db_en    (db_en[i]),
            .rise_en  (rise_en[i]),
            .fall_en  (fall_en[i]),
            .int_clr  (int_clr[i]),
            .stable   (gpio_in[i]),
            .status   (status[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status & ~int_mask);
        end
    end

    assign int_status = status;
    assign irq        = irq_q;

endmodule

// File: doc/verilab_pads_gpio_in_cond.md
Name: verilab_pads_gpio_in_cond

Overview:
GPIO input conditioner sitting directly downstream of the pad input buffers. Per pin it synchronises the raw pad value into clk, debounces it with a shared prescaled tick, and detects edges into sticky interrupt status. It produces one masked interrupt line. It feeds the GPIO register/interrupt block; its width tracks the project-wide maximum GPIO count.

Parameters:
GPIO, proj_param_pkg::PROJ_GPIO (32 in standalone bench), number of pins
PRESC_W, 16, prescaler width
DB_CNT_W, 8, debounce counter width

Ports:
clk  in  1  block clock
rst_n  in  1  asynchronous active-low reset
pad_in  in  GPIO  raw pad input, asynchronous to clk
presc  in  PRESC_W  tick period minus 1 (tick every presc+1 cycles)
db_limit  in  DB_CNT_W  ticks a changed level must persist before acceptance
db_en  in  GPIO  per-pin debounce enable; 0 = bypass
rise_en  in  GPIO  per-pin rising-edge interrupt enable
fall_en  in  GPIO  per-pin falling-edge interrupt enable
int_mask  in  GPIO  1 = pin masked from irq
int_clr  in  GPIO  one-cycle W1C pulse per pin
gpio_in  out  GPIO  conditioned (stable) pin value
int_status  out  GPIO  sticky edge status
irq  out  1  OR of unmasked status, registered

Behaviour:
- Reset: all sync flops, gpio_in, int_status, irq, prescaler and all debounce counters are 0. No edge is recorded on the first cycles after reset. Reset asserted mid-operation clears everything immediately (asynchronous).
- Synchroniser: two flops per pin, giving sync = pad_in delayed 2 cycles.
- Prescaler: free-running counter 0..presc. tick = 1 for one cycle when count == presc, then the counter wraps to 0.
  - presc == 0: tick every cycle.
  - A change of presc takes effect at the next wrap. If the counter is already > presc, it wraps to 0 next cycle.
- Debounce, per pin with db_en = 1:
  - sync == gpio_in: counter cleared.
  - sync != gpio_in and tick: counter increments.
  - When counter == db_limit at a tick, or when db_limit == 0 (mismatch seen on any cycle): gpio_in <= sync and the counter is cleared.
  - A glitch that returns before acceptance clears the counter; gpio_in does not change.
  - The counter saturates at all-ones and never wraps.
- Bypass (db_en = 0): gpio_in <= sync every cycle. Total latency from pad_in change to gpio_in is 3 clk edges. Counter held at 0.
- db_en toggled mid-count: counter cleared. The pin resumes in the new mode next cycle.
- Edge detect: rise = gpio_in 0->1, fall = 1->0, using a registered previous value.
  - A rise with rise_en, or a fall with fall_en, sets int_status[i] on the cycle after the gpio_in change.
  - Set and int_clr on the same cycle: set wins.
  - int_clr with no set: bit clears next cycle.
- irq <= |(int_status & ~int_mask), one cycle after int_status.
- All pins are independent. Simultaneous events on different pins do not interact.

Decomposition:
- Package verilab_pads_pkg holds DEFAULT_PRESC_W and DEFAULT_DB_CNT_W. GPIO comes from proj_param_pkg::PROJ_GPIO.
- Sub-module verilab_pads_gpio_db_cell: one pin's synchroniser, debounce counter, stable flop, edge detect and status bit. Generated GPIO times.
- Prescaler and irq reduction stay in the top.

Test Plan:
1. Reset/bypass: after reset, db_en = 0 and pad_in[0] 0->1 -> gpio_in[0] = 1 exactly 3 cycles later. With rise_en[0] = 1: int_status[0] = 1 on cycle 4 and irq = 1 on cycle 5.
2. Debounce accept: presc = 3, db_limit = 4, db_en[5] = 1, pad_in[5] held high -> gpio_in[5] rises after the 4th tick following sync mismatch, within 16 cycles ±4 of the pad change.
3. Glitch reject: same config, pad_in[5] high for 10 cycles then low -> gpio_in[5] stays 0 and int_status[5] stays 0.
4. Set/clear collision: drive int_clr[2] on the same cycle a falling edge sets int_status[2] with fall_en[2] = 1 -> int_status[2] remains 1. A later int_clr[2] alone -> 0 next cycle and irq drops one cycle after.
5. Mask: int_status[7] = 1 with int_mask[7] = 1 -> irq = 0. Clear the mask -> irq = 1 next cycle.
6. Boundaries: db_limit = 0 with debounce enabled -> gpio_in updates the cycle after the mismatch. presc = 0xFFFF with db_limit = 255 -> counter saturates without wrap. Async rst_n pulse mid-count -> all outputs 0, counters restart.
